// File: rtl/phase_sequencer.sv
// Read/process/write burst sequencer with request/acknowledge handshakes, abort and error state.
// Define PHASE_SEQUENCER_TIMEOUT_EN to enable the READ/WRITE handshake timeout into ERROR.
module phase_sequencer #(
  parameter int PROC_CYCLES    = 4,
  parameter int CNT_W          = 8,
  parameter int ITER_W         = 4,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ITER_W-1:0] burst_len,
  output logic              rd_req,
  input  logic              rd_ack,
  output logic              proc_en,
  output logic              wr_req,
  input  logic              wr_ack,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        state,
  output logic [ITER_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_PROC  = 3'd2,
    S_WRITE = 3'd3,
    S_ERROR = 3'd4
  } state_t;

`ifdef PHASE_SEQUENCER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] PROC_LAST = CNT_W'(PROC_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [ITER_W-1:0]   r_iter, w_iter_nxt;
  logic [ITER_W-1:0]   r_len, w_len_nxt;
  logic                r_done, w_done_nxt;
  logic                w_to_hit;
  logic                w_last;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_iter_nxt  = r_iter;
    w_len_nxt   = r_len;
    w_done_nxt  = 1'b0;
    // counter sits at TO_LAST on the final allowed cycle; an ack that cycle still wins
    w_to_hit    = TO_EN && (r_cnt == TO_LAST);
    w_last      = (r_iter == r_len - ITER_W'(1));
    if (abort && r_state != S_IDLE) begin
      w_state_nxt = S_IDLE;
      w_iter_nxt  = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          w_state_nxt = S_READ;
          w_iter_nxt  = '0;
          w_cnt_nxt   = '0;
          w_len_nxt   = (burst_len == '0) ? ITER_W'(1) : burst_len;
        end
        S_READ: begin
          if (rd_ack) begin
            w_state_nxt = S_PROC;
            w_cnt_nxt   = '0;
          end else if (w_to_hit) begin
            w_state_nxt = S_ERROR;
            w_cnt_nxt   = '0;
          end else if (TO_EN) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_PROC: begin
          if (r_cnt == PROC_LAST) begin
            w_state_nxt = S_WRITE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_WRITE: begin
          if (wr_ack) begin
            w_cnt_nxt = '0;
            if (w_last) begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_READ;
              w_iter_nxt  = r_iter + ITER_W'(1);
            end
          end else if (w_to_hit) begin
            w_state_nxt = S_ERROR;
            w_cnt_nxt   = '0;
          end else if (TO_EN) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_ERROR: ;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_iter  <= '0;
      r_len   <= ITER_W'(1);
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_iter  <= w_iter_nxt;
      r_len   <= w_len_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign rd_req   = (r_state == S_READ);
  assign proc_en  = (r_state == S_PROC);
  assign wr_req   = (r_state == S_WRITE);
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign state    = r_state;
  assign iter_cnt = r_iter;
`ifdef PHASE_SEQUENCER_TIMEOUT_EN
  assign err      = (r_state == S_ERROR);
`else
  assign err      = 1'b0;
`endif

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Parametrised successor to the team's IDLE/READ/PROCESS/WRITE control FSM.
- Adds a read and write request/acknowledge handshake, a fixed-length PROCESS dwell, a burst of repeated cycles per start, abort and an error state.
- Sits between the datapath control logic and a memory/peripheral port, sequencing one fetch-compute-store loop per iteration.

Parameters:
- PROC_CYCLES, 4, number of cycles proc_en is held high per iteration; legal range is 1 to 2**CNT_W-1.
- CNT_W, 8, width of the internal dwell/timeout counter.
- ITER_W, 4, width of burst_len and iter_cnt.
- TIMEOUT_CYCLES, 200, handshake timeout in cycles; used only with PHASE_SEQUENCER_TIMEOUT_EN; must be at most 2**CNT_W-1.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level, sampled in IDLE only.
- abort  in  1  synchronous abort; highest priority after reset.
- burst_len  in  ITER_W  iterations per start; 0 is treated as 1.
- rd_req  out  1  read request.
- rd_ack  in  1  read acknowledge.
- proc_en  out  1  processing enable.
- wr_req  out  1  write request.
- wr_ack  in  1  write acknowledge.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at burst completion.
- err  out  1  high while in ERROR.
- state  out  3  state code: IDLE=0, READ=1, PROCESS=2, WRITE=3, ERROR=4.
- iter_cnt  out  ITER_W  index of the current iteration, starting at 0.

Behaviour:
- Reset (asynchronous):
  - state=IDLE, iter_cnt=0, internal counter=0, latched burst length=1.
  - All outputs 0, including done.
  - Reset asserted mid-burst takes effect immediately; no done pulse is produced.
- Outputs decoded from registered state (Moore):
  - rd_req = (state==READ).
  - proc_en = (state==PROCESS).
  - wr_req = (state==WRITE).
  - busy = (state!=IDLE).
  - err = (state==ERROR).
- done is a registered output, high for exactly one cycle coincident with the first IDLE cycle after the final write is acknowledged.
- Priority at each edge: reset, then abort, then normal transitions.
- IDLE:
  - start=1 latches burst_len (0 becomes 1), clears iter_cnt and moves to READ.
  - abort is ignored in IDLE.
- READ:
  - rd_ack=1 clears the counter and moves to PROCESS.
  - Otherwise stay in READ.
  - rd_ack is ignored in every other state.
- PROCESS:
  - Counter increments each cycle.
  - After PROC_CYCLES cycles in PROCESS, move to WRITE and clear the counter.
- WRITE, on wr_ack=1:
  - If iter_cnt == latched length-1: go to IDLE and pulse done.
  - Otherwise: iter_cnt+1 and go to READ.
  - wr_ack is ignored outside WRITE.
- abort=1 in READ, PROCESS, WRITE or ERROR:
  - Next state is IDLE, iter_cnt=0, no done pulse.
  - abort with ack in the same cycle: abort wins.
- start while busy is ignored; the burst_len latch does not change mid-burst.
- Minimum latency, burst of 1 with acks available immediately:
  - start sampled at edge 0.
  - READ from edge 1.
  - PROCESS from edge 2.
  - WRITE from edge 2+PROC_CYCLES.
  - IDLE with done=1 from edge 3+PROC_CYCLES.
- start held high continuously: a new burst begins on the edge after done (done cycle is in IDLE, start sampled there).
- iter_cnt does not wrap: maximum burst is 2**ITER_W-1 iterations; burst_len=0 yields 1.

Optional Feature:
- PHASE_SEQUENCER_TIMEOUT_EN defined:
  - The counter runs in READ and WRITE, cleared on entry to each state.
  - If it reaches TIMEOUT_CYCLES with no ack, the next state is ERROR.
  - ERROR holds err=1 and busy=1 and ignores start and acks; it exits to IDLE only on abort or reset.
  - An ack arriving on the same cycle the counter hits TIMEOUT_CYCLES is accepted and the transition is normal.
- Not defined:
  - READ and WRITE wait indefinitely.
  - ERROR is unreachable and err is constant 0.

Test Plan:
- Single iteration, defaults: burst_len=1, pulse start, rd_ack/wr_ack tied 1 -> rd_req at edge 1, proc_en high for exactly 4 cycles, wr_req for 1 cycle, done single-cycle pulse at edge 7, busy low from edge 7.
- Burst: burst_len=3, acks delayed 2 cycles each -> three full READ/PROCESS/WRITE loops, iter_cnt 0,1,2, exactly one done pulse after the third wr_ack; burst_len=0 -> exactly 1 iteration.
- Abort: assert abort during PROCESS of iteration 1 of 3 -> IDLE next edge, iter_cnt=0, no done pulse; then start -> normal burst completes.
- Start and ack filtering: start pulsed while busy, rd_ack asserted during WRITE, wr_ack asserted during READ -> no state effect, no extra iterations.
- Async reset mid-WRITE -> all outputs 0 immediately before the next clock edge, state=0, no done pulse.
- Timeout (PHASE_SEQUENCER_TIMEOUT_EN, TIMEOUT_CYCLES=10):
  - rd_ack withheld -> ERROR after 10 cycles in READ, err=1, start ignored, abort returns to IDLE.
  - rd_ack on the 10th cycle -> PROCESS.
